// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with MUL/DIV occupancy sequencing.
// Define ALU_CTRL_EXC_EN for a sticky, ex_ack-cleared illegal-funct exception.
module alu_ctrl_seq #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   =
    $clog2((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] ALUop,
  input  logic [5:0] funct,
  input  logic       flush,
  input  logic       ex_ack,
  output logic [3:0] control_out,
  output logic       ctrl_valid,
  output logic       mdu_start,
  output logic       mdu_done,
  output logic       stall,
  output logic       ex
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_code;
  logic             r_cv;
  logic             r_start;
  logic             r_ex;
  logic [3:0]       w_code;
  logic             w_ill;
  logic             w_mul;
  logic             w_div;
  logic             w_accept;
  logic             w_ex_pending;

  always_comb begin
    w_code = 4'd3;
    w_ill  = 1'b0;
    w_mul  = 1'b0;
    w_div  = 1'b0;
    unique case (1'b1)
      ALUop[0]:        w_code = 4'd6;
      ALUop == 2'b00:  w_code = 4'd2;
      ALUop == 2'b10: begin
        case (funct)
          6'h20: w_code = 4'd2;
          6'h22: w_code = 4'd6;
          6'h24: w_code = 4'd0;
          6'h25: w_code = 4'd1;
          6'h2A: w_code = 4'd7;
          6'h18: begin
            w_code = 4'd5;
            w_mul  = 1'b1;
          end
          6'h1A: begin
            w_code = 4'd4;
            w_div  = 1'b1;
          end
          6'h00: w_code = 4'd8;
          6'h02: w_code = 4'd9;
          6'h03: w_code = 4'd12;
          6'h26: w_code = 4'd10;
          6'h27: w_code = 4'd11;
          default: begin
            w_code = 4'd3;
            w_ill  = 1'b1;
          end
        endcase
      end
      default: w_code = 4'd3;
    endcase
  end

  assign in_ready = (r_state == IDLE) & ~w_ex_pending;
  assign w_accept = in_valid & in_ready & ~flush;
  assign stall    = (r_state == BUSY);
  // An aborted op never reports completion, even on its last cycle.
  assign mdu_done = (r_state == BUSY) & (r_cnt == '0) & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept & (w_mul | w_div)) begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = w_mul ? CNT_W'(MUL_LAT - 1)
                                : CNT_W'(DIV_LAT - 1);
          end
        end
        BUSY: begin
          if (r_cnt == '0) w_state_nxt = IDLE;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= 4'd3;
      r_cv    <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_cv    <= w_accept;
      r_start <= w_accept & (w_mul | w_div);
      if (flush)         r_code <= 4'd3;
      else if (w_accept) r_code <= w_code;
    end
  end

`ifdef ALU_CTRL_EXC_EN
  assign w_ex_pending = r_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ex <= 1'b0;
    else if (w_accept & w_ill) r_ex <= 1'b1;
    else if (ex_ack)           r_ex <= 1'b0;
  end
`else
  logic w_unused;
  assign w_unused     = ex_ack;
  assign w_ex_pending = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ex <= 1'b0;
    else        r_ex <= w_accept & w_ill;
  end
`endif

  assign control_out = r_code;
  assign ctrl_valid  = r_cv;
  assign mdu_start   = r_start;
  assign ex          = r_ex;

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised successor to the combinational ALU control decoder in the EX stage. Accepts one decode request per cycle (ALUop plus funct) and produces the 4-bit ALU control code. Sequences multi-cycle MUL/DIV operations with a start/done handshake and a pipeline stall. Flags illegal R-format functs as an exception.

## Interface

Parameters:
- MUL_LAT, 4, MUL occupancy in cycles (legal range ≥2).
- DIV_LAT, 32, DIV occupancy in cycles (legal range ≥2).
- CNT_W, $clog2(max(MUL_LAT,DIV_LAT)), latency counter width (derived; do not override).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode request valid
- in_ready  out  1  request accepted when in_valid & in_ready & !flush
- ALUop  in  2  main-control ALU op
- funct  in  6  R-format funct field
- flush  in  1  synchronous abort of current/incoming operation
- ex_ack  in  1  clears sticky exception (only with ALU_CTRL_EXC_EN)
- control_out  out  4  registered ALU control code
- ctrl_valid  out  1  one-cycle pulse, control_out newly issued
- mdu_start  out  1  one-cycle pulse to MUL/DIV unit
- mdu_done  out  1  one-cycle pulse, last busy cycle
- stall  out  1  high while MUL/DIV occupies the block
- ex  out  1  illegal-funct exception

## Operation

- Decode, with ALUop priority x1 over 1x:
  - ALUop 00 → 2.
  - ALUop x1 → 6.
  - ALUop 10 → by funct: 0x20 add=2, 0x22 sub=6, 0x24 and=0, 0x25 or=1, 0x2A slt=7, 0x18 mul=5, 0x1A div=4, 0x00 sll=8, 0x02 srl=9, 0x03 sra=12, 0x26 xor=10, 0x27 nor=11.
  - Any other funct → 3 (illegal).
- States: IDLE, BUSY.
- In IDLE, in_ready = !ex_pending. ex_pending is always 0 without the macro.
- On accept of a single-cycle op:
  - Register control_out and pulse ctrl_valid.
  - Stay in IDLE; back-to-back accepts are allowed every cycle.
- On accept of mul or div:
  - Register control_out and pulse ctrl_valid and mdu_start.
  - Go to BUSY with cnt = LAT-1.
- In BUSY:
  - in_ready=0, stall=1, and control_out is held.
  - cnt decrements each cycle.
  - When cnt==0, mdu_done=1; on the next edge, return to IDLE.
- Illegal funct: control_out=3, ctrl_valid pulses, and ex asserts (see Configuration). The op is treated as single-cycle.
- Flush: takes precedence over accept and BUSY.
  - Next state is IDLE, control_out=3, and ctrl_valid, stall and mdu_done are 0.
  - No mdu_done is issued for an aborted op.
  - Flush does not clear the sticky ex.

## Timing

- Reset values: control_out=4'b0011, ctrl_valid=0, mdu_start=0, mdu_done=0, stall=0, ex=0, state IDLE, cnt=0. in_ready=1 once reset is released.
- Decode latency is 1 cycle: accept at edge T, and control_out/ctrl_valid are valid in cycle T+1.
- For a MUL/DIV accepted at edge T:
  - stall is high in cycles T+1 … T+LAT.
  - mdu_start is high in T+1; mdu_done is high in T+LAT.
  - in_ready rises in T+LAT+1.
- in_valid must be held while in_ready=0; no request is dropped except on flush.
- Reset asserted mid-BUSY returns all outputs to reset values immediately (asynchronous).
- flush and mdu_done coincident (cnt==0): flush wins, and mdu_done is suppressed in the following state.
- in_ready is combinational from state and ex_pending only; it never depends on in_valid.

## Configuration

- ALU_CTRL_EXC_EN defined:
  - ex is sticky (ex_pending) from T+1 of an illegal accept until the cycle after ex_ack=1.
  - in_ready=0 while ex_pending.
  - ex_ack with no pending ex is ignored.
- Not defined:
  - ex is a one-cycle pulse aligned with ctrl_valid.
  - ex_ack is ignored and the block never blocks on exceptions.

## Test plan

- Reset, then ALUop=10/funct=0x20, 0x22, 0x2A on consecutive cycles → control_out 2, 6, 7 in consecutive cycles, ctrl_valid held 1, in_ready stays 1.
- ALUop=10/funct=0x18, MUL_LAT=4, accept at T → mdu_start at T+1, stall T+1..T+4, mdu_done at T+4, a second request held on in_valid is accepted at T+5.
- DIV (funct 0x1A, DIV_LAT=32) with flush at T+10 → stall drops at T+11, control_out=3, no mdu_done, next request accepted at T+11.
- ALUop=10/funct=0x3F → control_out=3 and ex=1.
  - With ALU_CTRL_EXC_EN: ex and in_ready=0 persist until ex_ack, then clear one cycle later.
  - Without it: single-cycle ex pulse.
- ALUop=01, ALUop=11 and ALUop=00 with arbitrary funct → 6, 6, 2; funct=0x02 → 9 and funct=0x03 → 12 (no mul/srl alias).
- rst_n asserted at T+2 of a MUL → all outputs go to reset values asynchronously; the first request after release decodes normally.
